// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation codes, opcode width and default operation latencies.
package mdu_pkg;

  localparam int OP_W        = 4;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  typedef enum logic [OP_W-1:0] {
    mduNone  = 4'd0,
    mduMult  = 4'd1,
    mduMultu = 4'd2,
    mduDiv   = 4'd3,
    mduDivu  = 4'd4,
    mduMfhi  = 4'd5,
    mduMflo  = 4'd6,
    mduMthi  = 4'd7,
    mduMtlo  = 4'd8
  } mdu_op_e;

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational arithmetic core of the MDU: 64-bit product, or
// quotient/remainder, with a signed/unsigned select. Results are laid out
// the way HI/LO expect them (remainder/quotient or product high/low).
module mdu_arith (
  input  logic        is_signed,
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Multiply on extended operands and divide on magnitudes, then restore signs
  // so that the quotient truncates toward zero and the remainder follows the
  // dividend. 0x80000000 / -1 wraps naturally to LO=0x80000000, HI=0.
  always_comb begin
    a_ext   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    product = a_ext * b_ext;
    a_neg   = is_signed & a[31];
    b_neg   = is_signed & b[31];
    a_mag   = a_neg ? (32'd0 - a) : a;
    b_mag   = b_neg ? (32'd0 - b) : b;
    b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;
    res_hi  = is_div ? rem  : product[63:32];
    res_lo  = is_div ? quot : product[31:0];
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit. The result is computed when a start is
// accepted and held in pend_hi/pend_lo; HI/LO only change after the modelled
// latency has elapsed, so mfhi/mflo never see an in-flight result.
module e_mdu #(
  parameter int MULT_CYCLES = mdu_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = mdu_pkg::DIV_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              MDU_a,
  input  logic [31:0]              MDU_b,
  input  logic [mdu_pkg::OP_W-1:0] CU_MDU_op,
  input  logic                     MDU_start,
  output logic [31:0]              E_MDU_out,
  output logic                     E_MDU_busy,
  output logic                     E_MDU_stall
);

  import mdu_pkg::*;

  logic [31:0] hi;
  logic [31:0] lo;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic        is_arith;
  logic        is_signed;
  logic        is_div;
  logic        accept;
  logic        div_zero;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Classify the opcode; unknown codes fall through as no operation.
  always_comb begin
    is_arith  = 1'b0;
    is_signed = 1'b0;
    is_div    = 1'b0;
    case (CU_MDU_op)
      mduMult:  begin is_arith = 1'b1; is_signed = 1'b1; end
      mduMultu: begin is_arith = 1'b1; end
      mduDiv:   begin is_arith = 1'b1; is_signed = 1'b1; is_div = 1'b1; end
      mduDivu:  begin is_arith = 1'b1; is_div = 1'b1; end
      default:  ;
    endcase
  end

  assign E_MDU_busy  = (cnt != 4'd0);
  assign E_MDU_stall = E_MDU_busy | MDU_start;
  assign accept      = MDU_start & ~E_MDU_busy & is_arith;
  assign div_zero    = is_div & (MDU_b == 32'd0);

  mdu_arith u_arith (
    .is_signed (is_signed),
    .is_div    (is_div),
    .a         (MDU_a),
    .b         (MDU_b),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // Count down an in-flight operation and commit on its last busy cycle;
  // otherwise accept a new start or a direct HI/LO write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else if (E_MDU_busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (accept) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= ~div_zero;
      cnt     <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (CU_MDU_op == mduMthi) begin
      hi <= MDU_a;
    end else if (CU_MDU_op == mduMtlo) begin
      lo <= MDU_a;
    end
  end

  // Read port shows only committed HI/LO.
  always_comb begin
    E_MDU_out = 32'd0;
    case (CU_MDU_op)
      mduMfhi: E_MDU_out = hi;
      mduMflo: E_MDU_out = lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios with literal expectations
// followed by randomized traffic, all checked each cycle against a
// timestamp-based behavioural model.
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] MDU_a = 32'd0;
  logic [31:0] MDU_b = 32'd0;
  logic [3:0]  CU_MDU_op = 4'd0;
  logic        MDU_start = 1'b0;
  logic [31:0] E_MDU_out;
  logic        E_MDU_busy;
  logic        E_MDU_stall;

  int compared = 0;
  int mismatched = 0;

  // behavioural model state: committed registers plus the edge at which the
  // current operation finishes
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  logic [31:0] pHi = 32'd0;
  logic [31:0] pLo = 32'd0;
  bit          pWr = 1'b0;
  int          edgeNum = 0;
  int          doneEdge = 0;

  bit          checkEn = 1'b0;
  bit          pinValid = 1'b0;
  int          pinKind = 0;
  string       pinName = "";
  logic [31:0] pinExp = 32'd0;
  int          runLen = 0;
  int          lastRun = 0;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .MDU_a       (MDU_a),
    .MDU_b       (MDU_b),
    .CU_MDU_op   (CU_MDU_op),
    .MDU_start   (MDU_start),
    .E_MDU_out   (E_MDU_out),
    .E_MDU_busy  (E_MDU_busy),
    .E_MDU_stall (E_MDU_stall)
  );

  // reference arithmetic straight from the operation definitions
  function automatic void refCompute(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] h,
                                     output logic [31:0] l, output bit wr);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    int si, sj;
    h = 32'd0; l = 32'd0; wr = 1'b1;
    case (op)
      4'd1: begin
        sa = longint'($signed(a)); sb = longint'($signed(b)); sp = sa * sb;
        h = sp[63:32]; l = sp[31:0];
      end
      4'd2: begin
        ua = {32'd0, a}; ub = {32'd0, b}; up = ua * ub;
        h = up[63:32]; l = up[31:0];
      end
      4'd3: begin
        if (b == 32'd0) wr = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'd0;
        end else begin
          si = $signed(a); sj = $signed(b);
          l = 32'(si / sj); h = 32'(si % sj);
        end
      end
      4'd4: begin
        if (b == 32'd0) wr = 1'b0;
        else begin l = a / b; h = a % b; end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  // model: results land at the edge the latency expires; starts and direct
  // writes only take effect when nothing is in flight
  always @(posedge clk or negedge reset_n) begin : model
    bit wasBusy;
    if (!reset_n) begin
      mHi = 32'd0; mLo = 32'd0; pHi = 32'd0; pLo = 32'd0; pWr = 1'b0; doneEdge = 0;
    end else begin
      edgeNum++;
      wasBusy = (edgeNum - 1) < doneEdge;
      if (wasBusy && edgeNum == doneEdge && pWr) begin
        mHi = pHi; mLo = pLo;
      end
      if (!wasBusy) begin
        if (MDU_start && CU_MDU_op >= 4'd1 && CU_MDU_op <= 4'd4) begin
          refCompute(CU_MDU_op, MDU_a, MDU_b, pHi, pLo, pWr);
          doneEdge = edgeNum + ((CU_MDU_op >= 4'd3) ? DIV_CYCLES : MULT_CYCLES);
        end else if (CU_MDU_op == 4'd7) mHi = MDU_a;
        else if (CU_MDU_op == 4'd8) mLo = MDU_a;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: model check every cycle plus any pinned literal
  always @(negedge clk) begin : compare
    logic [31:0] expOut;
    logic        expBusy;
    logic [31:0] act;
    if (E_MDU_busy) runLen++;
    else if (runLen != 0) begin lastRun = runLen; runLen = 0; end
    if (checkEn) begin
      expBusy = edgeNum < doneEdge;
      expOut  = (CU_MDU_op == 4'd5) ? mHi : (CU_MDU_op == 4'd6) ? mLo : 32'd0;
      checkOutput("model_out", E_MDU_out, expOut);
      checkOutput("model_busy", {31'd0, E_MDU_busy}, {31'd0, expBusy});
      checkOutput("model_stall", {31'd0, E_MDU_stall}, {31'd0, expBusy | MDU_start});
    end
    if (pinValid) begin
      case (pinKind)
        0:       act = E_MDU_out;
        1:       act = {31'd0, E_MDU_busy};
        2:       act = {31'd0, E_MDU_stall};
        default: act = 32'(lastRun);
      endcase
      checkOutput(pinName, act, pinExp);
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic start);
    @(posedge clk); #1;
    CU_MDU_op = op; MDU_a = a; MDU_b = b; MDU_start = start;
  endtask

  // kind: 0 out, 1 busy, 2 stall, 3 length of last busy run
  task automatic pinCheck(input int kind, input string name, input logic [31:0] exp);
    pinKind = kind; pinName = name; pinExp = exp; pinValid = 1'b1;
    @(negedge clk); #1;
    pinValid = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] op, input string name, input logic [31:0] exp);
    applyStimulus(op, 32'd0, 32'd0, 1'b0);
    pinCheck(0, name, exp);
  endtask

  task automatic startOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(op, a, b, 1'b1);
    pinCheck(2, "stall_in_start_cycle", 32'd1);
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!E_MDU_busy) break;
    end
  endtask

  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int n, input string name);
    startOp(op, a, b);
    waitIdle();
    pinCheck(1, {name, "_idle"}, 32'd0);
    pinCheck(3, {name, "_busy_len"}, 32'(n));
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    logic [3:0] op;
    logic       st;
    int         r;
    #1 reset_n = 1'b0;
    #1 checkEn = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    pinCheck(1, "reset_busy", 32'd0);
    readReg(4'd5, "reset_hi", 32'd0);
    readReg(4'd6, "reset_lo", 32'd0);

    runOp(4'd1, 32'hFFFF_FFFF, 32'd2, 5, "mult");
    readReg(4'd5, "mult_hi", 32'hFFFF_FFFF);
    readReg(4'd6, "mult_lo", 32'hFFFF_FFFE);

    runOp(4'd2, 32'hFFFF_FFFF, 32'd2, 5, "multu");
    readReg(4'd5, "multu_hi", 32'h0000_0001);
    readReg(4'd6, "multu_lo", 32'hFFFF_FFFE);

    runOp(4'd3, 32'hFFFF_FFF9, 32'd2, 10, "div");
    readReg(4'd6, "div_lo", 32'hFFFF_FFFD);
    readReg(4'd5, "div_hi", 32'hFFFF_FFFF);

    runOp(4'd4, 32'd7, 32'd2, 10, "divu");
    readReg(4'd6, "divu_lo", 32'd3);
    readReg(4'd5, "divu_hi", 32'd1);

    // divide by zero keeps HI/LO; a mtlo while busy is dropped
    applyStimulus(4'd7, 32'h1234, 32'd0, 1'b0);
    applyStimulus(4'd8, 32'h5678, 32'd0, 1'b0);
    startOp(4'd4, 32'd9, 32'd0);
    applyStimulus(4'd8, 32'hAAAA, 32'd0, 1'b0);
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    waitIdle();
    pinCheck(3, "divzero_busy_len", 32'd10);
    readReg(4'd5, "divzero_hi", 32'h1234);
    readReg(4'd6, "divzero_lo", 32'h5678);

    // start during busy cycle 2 is ignored
    startOp(4'd1, 32'd3, 32'd5);
    applyStimulus(4'd4, 32'd7, 32'd2, 1'b1);
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    waitIdle();
    pinCheck(3, "ignored_start_busy_len", 32'd5);
    readReg(4'd5, "ignored_start_hi", 32'd0);
    readReg(4'd6, "ignored_start_lo", 32'd15);

    // mflo shows old LO while busy and the new LO in the first idle cycle
    applyStimulus(4'd1, 32'd4, 32'd4, 1'b1);
    applyStimulus(4'd6, 32'd0, 32'd0, 1'b0);
    pinCheck(0, "mflo_busy_first", 32'd15);
    repeat (4) applyStimulus(4'd6, 32'd0, 32'd0, 1'b0);
    pinCheck(0, "mflo_busy_last", 32'd15);
    applyStimulus(4'd6, 32'd0, 32'd0, 1'b0);
    pinCheck(0, "mflo_first_idle", 32'd16);

    // reset in busy cycle 3 of a div aborts it
    startOp(4'd3, 32'd100, 32'd7);
    applyStimulus(4'd6, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1 reset_n = 1'b0;
    pinCheck(1, "reset_mid_busy", 32'd0);
    pinCheck(0, "reset_mid_lo", 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (15) applyStimulus(4'd6, 32'd0, 32'd0, 1'b0);
    pinCheck(0, "after_reset_lo", 32'd0);
    readReg(4'd5, "after_reset_hi", 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      op = 4'($urandom_range(1, 4));
      else if (r < 8) op = 4'($urandom_range(5, 8));
      else if (r < 9) op = 4'($urandom_range(9, 15));
      else            op = 4'd0;
      st = (op >= 4'd1 && op <= 4'd4) ? ($urandom_range(0, 3) != 0) : 1'b0;
      applyStimulus(op, pickOperand(), pickOperand(), st);
    end
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0);
    waitIdle();
    pinCheck(1, "final_idle", 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit, sitting beside the E-stage ALU and fed the same forwarded operands. It executes mult/multu/div/divu with multi-cycle latency into private HI/LO registers, serves mfhi/mflo reads and mthi/mtlo writes, and raises busy/stall so the hazard unit can hold D while an operation is in flight. Its read result is muxed with the ALU result into the E/M pipeline register.

## Interface

- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:

- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `MDU_a` in 32: forwarded rs operand.
- `MDU_b` in 32: forwarded rt operand.
- `CU_MDU_op` in 4: operation code of the instruction currently in E.
- `MDU_start` in 1: E holds a valid, unflushed mult/multu/div/divu this cycle.
- `E_MDU_out` out 32: HI for mfhi, LO for mflo, 0 otherwise.
- `E_MDU_busy` out 1: operation in flight.
- `E_MDU_stall` out 1: `E_MDU_busy | MDU_start`. The hazard unit stalls D on this when D holds any MDU instruction.

## Operation

- Opcodes, 4-bit:
  - 0000 none
  - 0001 mult
  - 0010 multu
  - 0011 div
  - 0100 divu
  - 0101 mfhi
  - 0110 mflo
  - 0111 mthi
  - 1000 mtlo
  - Anything else is treated as none.
- State: `HI`, `LO` (32 each), `cnt` (4 bits), `pend_hi`, `pend_lo` (32 each), `pend_wr` (1).
- Accepted start: `MDU_start` high, `E_MDU_busy` low, and op is 0001–0100. On the edge:
  - Operands are consumed; `pend_hi`/`pend_lo` are computed and captured.
  - `cnt` is loaded with `MULT_CYCLES` or `DIV_CYCLES`.
- mult/multu: full 64-bit signed/unsigned product. `pend_hi` = bits [63:32], `pend_lo` = bits [31:0].
- div/divu: signed/unsigned division. `pend_lo` = quotient, `pend_hi` = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero: start is accepted and busy runs for the full `DIV_CYCLES`, but `pend_wr` = 0. HI/LO stay unchanged.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- `E_MDU_busy` = (`cnt` != 0). Each busy cycle `cnt` decrements.
- On the edge where `cnt` goes 1→0: if `pend_wr`, then HI ← `pend_hi` and LO ← `pend_lo`.
- mthi/mtlo: HI or LO ← `MDU_a` on the edge, only when not busy. They are ignored while busy (the hazard unit guarantees this never happens).
- mfhi/mflo: `E_MDU_out` is combinational from the committed HI/LO. It never shows pending results.
- Start while busy is ignored. No queueing; the in-flight operation is unaffected.

## Timing

- Reset (asynchronous, `reset_n` low) clears HI, LO, `cnt`, `pend_*` and `pend_wr` to 0.
  - `E_MDU_out` = 0, `E_MDU_busy` = 0, `E_MDU_stall` = `MDU_start`.
  - Reset mid-operation aborts it with no HI/LO write.
- Start accepted at edge t:
  - `E_MDU_busy` is high for exactly N cycles (t+1 … t+N, N = `MULT_CYCLES` or `DIV_CYCLES`).
  - HI/LO are updated at edge t+N. `E_MDU_busy` is low from t+N.
- A new start in the cycle after busy falls is accepted (back-to-back gap 0).
- mfhi issued in the first non-busy cycle reads the new result.
- `E_MDU_stall` is high in the start cycle, so a dependent instruction in D is held from the first cycle.

## Structure

- Shared package `mdu_pkg`:
  - opcode constants (`mduNone` … `mduMtlo`);
  - default latencies `MULT_CYCLES`/`DIV_CYCLES`;
  - `CU_MDU_op` width.
- Single module. No sub-module is required.
  - The optional natural split is `mdu_arith`: a combinational 64-bit product and quotient/remainder with signed/unsigned select.

## Test plan

- mult with a=0xFFFFFFFF, b=2 → busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div with a=0xFFFFFFF9 (-7), b=2 → busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu with a=7, b=2 → LO=3, HI=1.
- divu with b=0 after mthi 0x1234, mtlo 0x5678 → busy for 10 cycles; HI/LO stay 0x1234/0x5678.
- Start mult, then assert `MDU_start` with divu in busy cycle 2 → ignored; busy stays 5 cycles total; only the mult result is committed.
- mflo during busy → old LO on `E_MDU_out`.
  - mflo in the first non-busy cycle → new LO.
  - mtlo 0xAAAA while busy → LO not changed.
- Drive `reset_n` low in busy cycle 3 of a div → busy = 0 and HI/LO = 0 immediately. No write occurs after reset is released.
